// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor (addsub_pipe).
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Signed saturation limits for a w-bit result, w <= 128.
  function automatic logic [127:0] sat_max(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] sat_min(input int w);
    return 128'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One CHUNK-wide slice of addsub_pipe. The in-flight word starts as operand A and
// each stage overwrites its own chunk with the partial sum. ADDSUB_SATURATE_EN clamps in the LAST stage.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0,
  parameter int LAST  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_x,
  input  logic [WIDTH-1:0] up_b,
  input  logic             up_c,
  output logic             vld,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] b,
  output logic             c,
  output logic             ovf
);

  localparam int LO = IDX * CHUNK;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  logic [CHUNK:0]     part;
  logic [WIDTH-1:0]   nxt_x;
  logic               nxt_ovf;

  always_comb begin
    part    = {1'b0, up_x[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]} + {{CHUNK{1'b0}}, up_c};
    nxt_x   = up_x;
    nxt_x[LO +: CHUNK] = part[CHUNK-1:0];
    nxt_ovf = 1'b0;
    if (LAST != 0) begin
      // Here up_x still holds A's top chunk, so a^b^s at the MSB is the carry into it.
      nxt_ovf = (up_x[WIDTH-1] ^ up_b[WIDTH-1] ^ part[CHUNK-1]) ^ part[CHUNK];
`ifdef ADDSUB_SATURATE_EN
      if (nxt_ovf) nxt_x = up_x[WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      x   <= '0;
      b   <= '0;
      c   <= 1'b0;
      ovf <= 1'b0;
    end else if (adv) begin
      vld <= up_vld;
      if (up_vld) begin
        x   <= nxt_x;
        b   <= up_b;
        c   <= part[CHUNK];
        ovf <= nxt_ovf;
      end
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, STAGES chunks with registered carries,
// valid/ready on both sides. Define ADDSUB_SATURATE_EN to clamp on signed overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  // Handshake: a beat transfers on a side only in a cycle where both valid and ready
  // are high; in_ready is combinational from out_ready and stage occupancy.

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("addsub_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic [STAGES:0]  vld_s;
  logic [STAGES:0]  c_s;
  logic [WIDTH-1:0] x_s [STAGES+1];
  logic [WIDTH-1:0] b_s [STAGES+1];
  logic             ovf_s [STAGES];
  logic [STAGES-1:0] adv;
  logic             open;

  assign vld_s[0] = in_valid;
  assign x_s[0]   = in_a;
  assign b_s[0]   = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign c_s[0]   = (in_sub == OP_SUB);

  // A stage may load if it is empty or anything downstream of it can move.
  always_comb begin
    open = out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      open   = open | ~vld_s[k+1];
      adv[k] = open;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k),
      .LAST  ((k == STAGES - 1) ? 1 : 0)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv[k]),
      .up_vld (vld_s[k]),
      .up_x   (x_s[k]),
      .up_b   (b_s[k]),
      .up_c   (c_s[k]),
      .vld    (vld_s[k+1]),
      .x      (x_s[k+1]),
      .b      (b_s[k+1]),
      .c      (c_s[k+1]),
      .ovf    (ovf_s[k])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_s[STAGES];
  assign out_sum   = x_s[STAGES];
  assign out_cout  = c_s[STAGES];
  assign out_ovf   = ovf_s[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (16/4 main instance, 32/2 and 8/8 sweep instances).
// Honours ADDSUB_SATURATE_EN in its reference model.
module tb_addsub_pipe;
  import addsub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main DUT 16/4
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] in_a, in_b, out_sum;
  // sweep DUTs
  logic        w32_in_valid, w32_in_ready, w32_in_sub, w32_out_valid, w32_out_ready, w32_out_cout, w32_out_ovf;
  logic [31:0] w32_in_a, w32_in_b, w32_out_sum;
  logic        w8_in_valid, w8_in_ready, w8_in_sub, w8_out_valid, w8_out_ready, w8_out_cout, w8_out_ovf;
  logic [7:0]  w8_in_a, w8_in_b, w8_out_sum;

  logic [17:0] exp_q[$];
  logic [33:0] exp_q32[$];
  logic [9:0]  exp_q8[$];

  addsub_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf));

  addsub_pipe #(.WIDTH(32), .STAGES(2)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(w32_in_valid), .in_ready(w32_in_ready), .in_a(w32_in_a),
    .in_b(w32_in_b), .in_sub(w32_in_sub), .out_valid(w32_out_valid), .out_ready(w32_out_ready),
    .out_sum(w32_out_sum), .out_cout(w32_out_cout), .out_ovf(w32_out_ovf));

  addsub_pipe #(.WIDTH(8), .STAGES(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_a(w8_in_a),
    .in_b(w8_in_b), .in_sub(w8_in_sub), .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .out_sum(w8_out_sum), .out_cout(w8_out_cout), .out_ovf(w8_out_ovf));

  // ---------------- reference model ----------------
  // Integer arithmetic on the operand values: returns {ovf, cout, sum}.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic sub);
    longint ua, ub, sa, sb, ur, sr, lim;
    logic [63:0] sum;
    logic cout, ovf;
    lim  = longint'(1) << w;
    ua   = a;
    ub   = b;
    sa   = a[w-1] ? ua - lim : ua;
    sb   = b[w-1] ? ub - lim : ub;
    ur   = sub ? ua - ub : ua + ub;
    cout = sub ? (ua >= ub) : (ur >= lim);
    sr   = sub ? sa - sb : sa + sb;
    ovf  = (sr >= lim / 2) || (sr < -(lim / 2));
    sum  = ur & (lim - 1);
`ifdef ADDSUB_SATURATE_EN
    if (ovf) sum = (sa < 0) ? lim / 2 : lim / 2 - 1;
`endif
    return {ovf, cout, sum};
  endfunction

  function automatic logic [63:0] pick(input int w);
    longint lim;
    lim = longint'(1) << w;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return lim - 1;
      2:       return lim / 2;
      3:       return lim / 2 - 1;
      default: return {$urandom(), $urandom()} & (lim - 1);
    endcase
  endfunction

  function automatic logic [17:0] exp16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [65:0] r;
    r = model(16, {48'd0, a}, {48'd0, b}, s);
    return {r[65], r[64], r[15:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic r);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sub    = s;
    out_ready = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, '0, '0, OP_ADD, 1'b0);
    w32_in_valid = 0; w32_in_a = 0; w32_in_b = 0; w32_in_sub = 0; w32_out_ready = 0;
    w8_in_valid = 0;  w8_in_a = 0;  w8_in_b = 0;  w8_in_sub = 0;  w8_out_ready = 0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 16'd0) begin errors++; $display("FAIL reset_out_sum got=%h exp=0000", out_sum); end
    checks++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", out_cout, out_ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a_v [3];
    logic [15:0] b_v [3];
    logic [15:0] s_v [3];
    a_v = '{16'd256, 16'd16383, 16'd16383};
    b_v = '{16'd76, 16'd0, 16'd1};
    s_v = '{16'd332, 16'd16383, 16'd16384};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 3) drive(1'b1, a_v[c], b_v[c], OP_ADD, 1'b1);
      else       drive(1'b0, '0, '0, OP_ADD, 1'b1);
      #1;
      if (c < 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      checks++;
      if (out_valid !== (c >= 4 && c <= 6)) begin
        errors++; $display("FAIL b2b_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4 && c <= 6));
      end
      if (c >= 4 && c <= 6) begin
        checks++; if (out_sum !== s_v[c-4]) begin errors++; $display("FAIL b2b_sum c=%0d got=%0d exp=%0d", c, out_sum, s_v[c-4]); end
      end
    end
  endtask

  task automatic test_directed;
    logic [15:0] a_v [4];
    logic [15:0] b_v [4];
    logic        op_v [4];
    logic [15:0] s_v [4];
    logic        c_v [4];
    logic        o_v [4];
    int k;
    a_v  = '{16'hFFFF, 16'h7FFF, 16'd5, 16'h8000};
    b_v  = '{16'd24, 16'd1, 16'd7, 16'd1};
    op_v = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
`ifdef ADDSUB_SATURATE_EN
    s_v  = '{16'd23, 16'h7FFF, 16'hFFFE, 16'h8000};
`else
    s_v  = '{16'd23, 16'h8000, 16'hFFFE, 16'h7FFF};
`endif
    c_v  = '{1'b1, 1'b0, 1'b0, 1'b1};
    o_v  = '{1'b0, 1'b1, 1'b0, 1'b1};
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 4) drive(1'b1, a_v[c], b_v[c], op_v[c], 1'b1);
      else       drive(1'b0, '0, '0, OP_ADD, 1'b1);
      #1;
      if (out_valid && k < 4) begin
        checks++;
        if ({out_ovf, out_cout, out_sum} !== {o_v[k], c_v[k], s_v[k]}) begin
          errors++;
          $display("FAIL directed_%0d got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                   k, out_sum, out_cout, out_ovf, s_v[k], c_v[k], o_v[k]);
        end
        k++;
      end
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL directed_count got=%0d exp=4", k); end
  endtask

  task automatic test_backpressure;
    logic [15:0] a, b, held;
    logic        s;
    logic [17:0] e;
    int sent, got;
    sent = 0; got = 0; held = '0;
    a = 16'($urandom()); b = 16'($urandom()); s = 1'($urandom());
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drive(sent < 8, a, b, s, !(c >= 3 && c <= 9));
      #1;
      checks++;
      if (in_ready !== !(c >= 4 && c <= 9)) begin
        errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, !(c >= 4 && c <= 9));
      end
      if (c == 4) begin
        held = out_sum;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got=%b exp=1", out_valid); end
      end
      if (c >= 5 && c <= 9) begin
        checks++; if (out_sum !== held) begin errors++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c, out_sum, held); end
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        checks++;
        if ({out_ovf, out_cout, out_sum} !== e) begin
          errors++; $display("FAIL bp_result_%0d got=%h exp=%h", got, {out_ovf, out_cout, out_sum}, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(exp16(a, b, s));
        sent++;
        a = 16'($urandom()); b = 16'($urandom()); s = 1'($urandom());
      end
    end
    checks++; if (got !== 8 || exp_q.size() !== 0) begin errors++; $display("FAIL bp_count got=%0d exp=8 left=%0d", got, exp_q.size()); end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic        s, v;
    logic [17:0] e;
    a = 16'(pick(16)); b = 16'(pick(16)); s = 1'($urandom()); v = ($urandom_range(0, 9) < 7);
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      if (c < 300) drive(v, a, b, s, ($urandom_range(0, 9) < 7));
      else         drive(1'b0, a, b, s, 1'b1);
      #1;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        checks++;
        if ({out_ovf, out_cout, out_sum} !== e) begin
          errors++; $display("FAIL rand16 c=%0d got=%h exp=%h", c, {out_ovf, out_cout, out_sum}, e);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(exp16(a, b, s));
      if (!in_valid || in_ready) begin
        a = 16'(pick(16)); b = 16'(pick(16)); s = 1'($urandom()); v = ($urandom_range(0, 9) < 7);
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand16_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 3) drive(1'b1, 16'(100 + c), 16'd1, OP_ADD, 1'b0);
      else       drive(1'b0, '0, '0, OP_ADD, 1'b0);
    end
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 16'd0) begin errors++; $display("FAIL rmid_async_sum got=%h exp=0000", out_sum); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b0, '0, '0, OP_ADD, 1'b1);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_sweep;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        s32, s8, v32, v8;
    logic [65:0] r;
    logic [33:0] e32;
    logic [9:0]  e8;
    a32 = 32'(pick(32)); b32 = 32'(pick(32)); s32 = 1'($urandom()); v32 = ($urandom_range(0, 3) != 0);
    a8  = 8'(pick(8));   b8  = 8'(pick(8));   s8  = 1'($urandom()); v8  = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < 330; c++) begin
      @(negedge clk);
      w32_in_valid = (c < 300) && v32; w32_in_a = a32; w32_in_b = b32; w32_in_sub = s32;
      w32_out_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
      w8_in_valid = (c < 300) && v8; w8_in_a = a8; w8_in_b = b8; w8_in_sub = s8;
      w8_out_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
      #1;
      if (w32_out_valid && w32_out_ready) begin
        e32 = (exp_q32.size() > 0) ? exp_q32.pop_front() : '1;
        checks++;
        if ({w32_out_ovf, w32_out_cout, w32_out_sum} !== e32) begin
          errors++; $display("FAIL sweep32 c=%0d got=%h exp=%h", c, {w32_out_ovf, w32_out_cout, w32_out_sum}, e32);
        end
      end
      if (w8_out_valid && w8_out_ready) begin
        e8 = (exp_q8.size() > 0) ? exp_q8.pop_front() : '1;
        checks++;
        if ({w8_out_ovf, w8_out_cout, w8_out_sum} !== e8) begin
          errors++; $display("FAIL sweep8 c=%0d got=%h exp=%h", c, {w8_out_ovf, w8_out_cout, w8_out_sum}, e8);
        end
      end
      if (w32_in_valid && w32_in_ready) begin
        r = model(32, {32'd0, a32}, {32'd0, b32}, s32);
        exp_q32.push_back({r[65], r[64], r[31:0]});
      end
      if (w8_in_valid && w8_in_ready) begin
        r = model(8, {56'd0, a8}, {56'd0, b8}, s8);
        exp_q8.push_back({r[65], r[64], r[7:0]});
      end
      if (!w32_in_valid || w32_in_ready) begin
        a32 = 32'(pick(32)); b32 = 32'(pick(32)); s32 = 1'($urandom()); v32 = ($urandom_range(0, 3) != 0);
      end
      if (!w8_in_valid || w8_in_ready) begin
        a8 = 8'(pick(8)); b8 = 8'(pick(8)); s8 = 1'($urandom()); v8 = ($urandom_range(0, 3) != 0);
      end
    end
    checks++; if (exp_q32.size() !== 0) begin errors++; $display("FAIL sweep32_drain got=%0d exp=0", exp_q32.size()); end
    checks++; if (exp_q8.size() !== 0) begin errors++; $display("FAIL sweep8_drain got=%0d exp=0", exp_q8.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
